write_buffer: RTL and testbench

- Write-through buffer between the data cache (memory stage) and the data memory.
- Absorbs store write-throughs so the pipeline stalls only when the buffer is full, not for every memory write latency.
- Drains entries in order to the data memory via its write handshake.
- Arbitrates the memory port against cache read misses, and holds a read miss back while any buffered write targets the same line.

---
 rtl/write_buffer.sv | 137 +++++++++++++
 tb/tb_write_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// write_buffer: write-through buffer between the data cache and data memory.
// Absorbs store write-throughs into a small in-order FIFO, drains them one at
// a time through the memory write handshake, coalesces repeated stores to the
// same word, and arbitrates the memory port against cache read misses. A read
// miss is held back while any buffered write targets the same cache line.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   wr_valid/addr/data  write-through request from the cache
//   wr_ready          write accepted this cycle (stall M when low)
//   rd_miss/rd_addr   pending read miss (held until rd_done)
//   rd_done           memory ReadReady for the current miss
//   rd_go             read miss may use the memory port
//   mem_write/addr/data  write request to memory (zeroed when idle)
//   mem_write_ready   memory write complete
//   empty, count      occupancy status
module write_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINE_OFF = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_miss,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_go,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_write_ready,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, stateNxt;

  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];
  logic [DEPTH-1:0]  entVld;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  cnt;

  logic [DEPTH-1:0]  hitVec, lineVec;
  logic [PTR_W-1:0]  hitIdx;
  logic              coalHit, rdConflict, isFull, push, pushNew, pop;

  // rd_done is implied by rd_miss falling; the buffer never needs it directly.
  logic unusedRdDone;
  assign unusedRdDone = rd_done;

  // Per-entry compare: word match for coalescing (the entry currently being
  // written to memory must not change under the handshake), line match for
  // read-after-write hazard detection (includes the in-flight head).
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hitVec[i]  = entVld[i] && (entAddr[i][ADDR_W-1:2] == wr_addr[ADDR_W-1:2])
                        && !(state == WAIT && head == PTR_W'(i));
    assign lineVec[i] = entVld[i] &&
                        (entAddr[i][ADDR_W-1:LINE_OFF] == rd_addr[ADDR_W-1:LINE_OFF]);
  end

  // At most one non-in-flight entry can hold a given word, so any priority works.
  always_comb begin
    hitIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (hitVec[i]) hitIdx = PTR_W'(i);
  end

  assign coalHit    = |hitVec;
  assign rdConflict = rd_miss && (|lineVec);
  assign isFull     = (cnt == CNT_W'(DEPTH));
  assign empty      = (cnt == '0);
  assign count      = cnt;

  // Writes are refused during a read miss so no new line conflict can appear
  // once rd_go has been granted.
  assign wr_ready = !rd_miss && (!isFull || coalHit);
  assign push     = wr_valid && wr_ready;
  assign pushNew  = push && !coalHit;

  assign rd_go = (state == IDLE) && rd_miss && !rdConflict;

  always_comb begin
    stateNxt  = state;
    mem_write = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty && (!rd_miss || rdConflict)) stateNxt = WAIT;
      WAIT: begin
        mem_write = 1'b1;
        if (mem_write_ready) begin
          pop      = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign mem_addr = mem_write ? entAddr[head] : '0;
  assign mem_data = mem_write ? entData[head] : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      entVld <= '0;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
    end else begin
      state <= stateNxt;
      if (push && coalHit) entData[hitIdx] <= wr_data;
      // tail==head only when empty or full; full never takes a new entry and
      // empty never pops, so these two updates never collide.
      if (pushNew) begin
        entAddr[tail] <= wr_addr;
        entData[tail] <= wr_data;
        entVld[tail]  <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        entVld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      cnt <= cnt + CNT_W'(pushNew) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: randomized check of write_buffer against a queue-based
// model of the buffer contents plus a flag for the write in flight.
module tb_write_buffer;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst, wr_valid, wr_ready, rd_miss, rd_done, rd_go;
  logic        mem_write, mem_write_ready, empty;
  logic [31:0] wr_addr, wr_data, rd_addr, mem_addr, mem_data;
  logic [2:0]  count;

  write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .LINE_OFF(4)) dut (
    .Clk(Clk), .Rst(Rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_miss(rd_miss), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_go(rd_go), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write_ready(mem_write_ready), .empty(empty), .count(count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit   inFl;
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs against the model,
  // then advance the model at the posedge.
  task automatic step(input bit rst, input bit wv, input logic [31:0] wa, input logic [31:0] wd,
                      input bit rm, input logic [31:0] ra, input bit rdn, input bit mwr,
                      output bit go);
    int hi;
    bit expWr, conf, expGo, nxtFl;
    Rst = rst; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_miss = rm; rd_addr = ra; rd_done = rdn; mem_write_ready = mwr;
    #1;
    hi = -1;
    conf = 1'b0;
    foreach (q[i]) begin
      if (hi < 0 && !(inFl && i == 0) && q[i].a[31:2] == wa[31:2]) hi = i;
      if (rm && q[i].a[31:4] == ra[31:4]) conf = 1'b1;
    end
    expWr = !rm && (q.size() < DEPTH || hi >= 0);
    expGo = rm && !conf && !inFl;
    go = rd_go;
    if (!rst) begin
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("wrReady", wr_ready, expWr);
      chk("rdGo", rd_go, expGo);
      chk("memWrite", mem_write, inFl);
      chk("memAddr", mem_addr, inFl ? q[0].a : 32'h0);
      chk("memData", mem_data, inFl ? q[0].d : 32'h0);
    end
    @(posedge Clk);
    if (rst) begin
      q.delete();
      inFl = 1'b0;
    end else begin
      nxtFl = inFl ? !mwr : (q.size() > 0 && (!rm || conf));
      if (wv && expWr && hi >= 0) q[hi].d = wd;
      if (inFl && mwr) void'(q.pop_front());
      if (wv && expWr && hi < 0) q.push_back('{a: wa, d: wd});
      inFl = nxtFl;
    end
    @(negedge Clk);
  endtask

  task automatic idle(input bit mwr, output bit go);
    step(0, 0, 0, 0, 0, 0, 0, mwr, go);
  endtask

  initial begin
    bit go, rm, rdn, rst;
    bit mActive;
    int goCnt, mAge;
    logic [31:0] mAddr, wa;
    mActive = 0; goCnt = 0; mAge = 0; mAddr = 0;
    @(negedge Clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, go);
    chk("rstCount", count, 0);
    chk("rstWrReady", wr_ready, 1);
    chk("rstEmpty", empty, 1);
    chk("rstMemWrite", mem_write, 0);

    // In-order drain with a 3-cycle memory latency.
    step(0, 1, 32'h100, 32'hAAAA, 0, 0, 0, 0, go);
    step(0, 1, 32'h104, 32'hBBBB, 0, 0, 0, 0, go);
    chk("twoCount", count, 2);
    for (int k = 0; k < 12; k++) idle(k % 4 == 3, go);
    chk("drainEmpty", empty, 1);

    // Full buffer with stalled memory rejects a new address.
    for (int k = 0; k < 4; k++) step(0, 1, 32'h600 + 32'(k) * 16, k, 0, 0, 0, 0, go);
    step(0, 1, 32'h700, 32'h5, 0, 0, 0, 0, go);
    chk("fullRdy", wr_ready, 0);
    chk("fullCount", count, 4);
    idle(1, go);
    chk("relRdy", wr_ready, 1);
    idle(0, go); idle(0, go);
    // Reset while a write is in flight with three entries left.
    chk("preRstCount", count, 3);
    chk("preRstMw", mem_write, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, go);
    chk("postRstCount", count, 0);
    chk("postRstMw", mem_write, 0);
    chk("postRstRdy", wr_ready, 1);

    // Coalesce into an entry behind the in-flight head.
    step(0, 1, 32'h200, 32'h1, 0, 0, 0, 0, go);
    step(0, 1, 32'h300, 32'h2, 0, 0, 0, 0, go);
    step(0, 1, 32'h300, 32'h3, 0, 0, 0, 0, go);
    chk("coalCount", count, 2);
    for (int k = 0; k < 6; k++) idle(1, go);

    // Same-line read miss waits for the drain; different line goes at once.
    step(0, 1, 32'h410, 32'h9, 0, 0, 0, 0, go);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 32'h41C, 0, k == 2, go);
    chk("confGo", go, 1);
    step(0, 0, 0, 0, 1, 32'h41C, 1, 0, go);
    step(0, 1, 32'h800, 32'h7, 0, 0, 0, 0, go);
    step(0, 0, 0, 0, 0, 0, 0, 0, go);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 32'h900, 0, 0, go);
    for (int k = 0; k < 4; k++) idle(1, go);

    // Randomized traffic over a few lines so coalescing and conflicts occur.
    for (int n = 0; n < 4000; n++) begin
      if (!mActive && $urandom_range(0, 15) == 0) begin
        mActive = 1; goCnt = 0; mAge = 0;
        mAddr = 32'h100 + ($urandom_range(0, 4) << 4) + ($urandom_range(0, 3) << 2);
      end
      rm = mActive;
      rdn = mActive && goCnt >= 3;
      rst = ($urandom_range(0, 599) == 0);
      wa = 32'h100 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
      step(rst, $urandom_range(0, 1), wa, $urandom, rm, mActive ? mAddr : $urandom,
           rdn, $urandom_range(0, 9) < 4, go);
      if (mActive) begin
        mAge++;
        if (go) goCnt++;
        if (rdn || rst) mActive = 0;
        else if (mAge > 300) begin
          chk("missTimeout", mAge, 0);
          mActive = 0;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
